multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Parametrised multicycle control unit for the RV32I core. Replaces the fixed-latency controller.
//  Sequences fetch/decode/execute/memory/writeback for all base opcodes incl. JALR, LUI, AUIPC.
//  Adds a mem_req/mem_ready handshake with wait states, full funct3 branch conditions,
//  and a sticky trap on illegal encodings or memory timeout. Sits between the instruction register
//  and the datapath muxes, ALU decoder, PC register and memory port.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive not-ready cycles in one memory state before trap; 0 = never time out
//  CNT_W        $clog2(MEM_TIMEOUT+1)  wait-counter width; derived, do not override
// PORTS
//  clk          in   1  clock, rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  opcode       in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  zero_flag    in   1  ALU result == 0
//  lt_flag      in   1  signed rs1 < rs2
//  ltu_flag     in   1  unsigned rs1 < rs2
//  mem_ready    in   1  memory completes current access this cycle
//  mem_req      out  1  memory access request; held until mem_ready
//  adr_src      out  1  0 = PC, 1 = result
//  ir_write     out  1  load instruction register
//  reg_write    out  1  register-file write enable
//  pc_update    out  1  PC write enable
//  pc_src       out  1  0 = increment (ALU result), 1 = jump target (ALUOut)
//  mem_write    out  1  store strobe
//  branch       out  1  high in BRANCH state
//  alu_src_a    out  2  0 = PC, 1 = old PC, 2 = rd1, 3 = zero
//  alu_src_b    out  2  0 = rd2, 1 = imm_ext, 2 = const 4
//  alu_op       out  3  000 = ADD, 001 = SUB/compare, 010 = R funct, 011 = I funct
//  result_src   out  2  0 = ALUOut, 1 = mem data, 2 = ALU result
//  fsm_state    out  5  current state encoding
//  trap         out  1  sticky trap indicator
//  trap_cause   out  2  0 = none, 1 = illegal opcode/funct3, 2 = memory timeout
// BEHAVIOUR
//  Reset and defaults
//  - reset_n low: state = FETCH, wait counter = 0, trap = 0, trap_cause = 0.
//  - While reset_n is low, every output is 0 (incl. mem_req and fsm_state).
//  - Outputs are combinational from the state. ir_write, mem_write, pc_update and reg_write
//    in memory states are additionally gated by mem_ready.
//  - Every output defaults to 0 in every state; no latched values.
//  State encodings
//  - FETCH = 0, DECODE = 1, EXECR = 2, EXECI = 3, JAL = 4, JALR_ADR = 5, JALR_PC = 6.
//  - LUI = 7, AUIPC = 8, MEMADR = 9, MEMREAD = 10, MEMWRITE = 11, MEMWB = 12.
//  - ALUWB = 13, BRANCH = 14, TRAP = 15.
//  FETCH
//  - mem_req = 1, adr_src = 0; ALU computes PC + 4 (a = 0, b = 2, ADD, result_src = 2).
//  - When mem_ready: ir_write = 1, pc_update = 1, pc_src = 0, go to DECODE; otherwise stay.
//  DECODE
//  - a = 1, b = 1, ADD (target into ALUOut).
//  - Next state by opcode: 0110011 EXECR, 0010011 EXECI, 1101111 JAL, 1100111 JALR_ADR,
//    0110111 LUI, 0010111 AUIPC, 0000011/0100011 MEMADR, 1100011 BRANCH.
//  - Any other opcode: TRAP, cause 1.
//  Execute and jump states
//  - EXECR: a = 2, b = 0, op 010. EXECI: a = 2, b = 1, op 011. LUI: a = 3, b = 1, ADD.
//    AUIPC: a = 1, b = 1, ADD. Each goes to ALUWB.
//  - JAL: pc_update = 1, pc_src = 1; a = 1, b = 2, ADD -> ALUWB.
//  - JALR_ADR: a = 2, b = 1, ADD -> JALR_PC.
//  - JALR_PC: pc_update = 1, pc_src = 1; a = 1, b = 2, ADD -> ALUWB.
//  - ALUWB: result_src = 0, reg_write = 1 -> FETCH.
//  Memory states
//  - MEMADR: a = 2, b = 1, ADD -> MEMREAD (load) or MEMWRITE (store).
//  - MEMREAD: mem_req = 1, adr_src = 1; mem_ready -> MEMWB.
//  - MEMWRITE: mem_req = 1, adr_src = 1, mem_write = mem_ready; mem_ready -> FETCH.
//  - MEMWB: result_src = 1, reg_write = 1 -> FETCH.
//  BRANCH
//  - a = 2, b = 0, op 001, branch = 1.
//  - taken = funct3 000 zero | 001 !zero | 100 lt | 101 !lt | 110 ltu | 111 !ltu.
//  - If taken: pc_update = 1, pc_src = 1. Not taken: pc_update = 0 (PC already advanced). -> FETCH.
//  - funct3 010/011: TRAP, cause 1, no PC write.
//  Wait counter
//  - Cleared on entry to FETCH/MEMREAD/MEMWRITE.
//  - Increments each cycle in those states with mem_ready = 0 (saturating at MEM_TIMEOUT).
//  - When it reaches MEM_TIMEOUT with mem_ready still 0 (MEM_TIMEOUT != 0): go to TRAP, cause 2.
//  - mem_ready on the same cycle the count reaches MEM_TIMEOUT: the access completes, no trap.
//  TRAP
//  - Absorbing until reset. All controls 0, trap = 1, trap_cause held.
//  - reset_n asserted mid-access: mem_req drops immediately and no partial write occurs.
// TESTING
//  - Reset, then ADD, mem_ready tied 1 -> states 0,1,2,13,0; reg_write only in state 13.
//  - LW, mem_ready low 3 cycles in MEMREAD -> state 10 held 4 cycles, mem_req held, then MEMWB.
//  - BNE with zero = 0 -> pc_update = 1, pc_src = 1. BNE with zero = 1 -> pc_update = 0.
//  - MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, trap_cause = 2,
//    state stays 15.
//  - Opcode 0000000, or BRANCH with funct3 = 010 -> TRAP, trap_cause = 1, no pc/reg/mem write.
//  - JALR, then reset_n pulsed low during MEMWRITE wait -> outputs 0 async, mem_write never high,
//    restart in FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit. It sequences fetch, decode, execute, memory and writeback,
// handles the mem_req/mem_ready handshake with a wait-state timeout, and raises a sticky trap.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero_flag,
  input  logic       lt_flag,
  input  logic       ltu_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_update,
  output logic       pc_src,
  output logic       mem_write,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic [4:0] fsm_state,
  output logic       trap,
  output logic [1:0] trap_cause
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_EXECR    = 5'd2,
    S_EXECI    = 5'd3,
    S_JAL      = 5'd4,
    S_JALR_ADR = 5'd5,
    S_JALR_PC  = 5'd6,
    S_LUI      = 5'd7,
    S_AUIPC    = 5'd8,
    S_MEMADR   = 5'd9,
    S_MEMREAD  = 5'd10,
    S_MEMWRITE = 5'd11,
    S_MEMWB    = 5'd12,
    S_ALUWB    = 5'd13,
    S_BRANCH   = 5'd14,
    S_TRAP     = 5'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       pc_src;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       cause;
  logic [1:0]       cause_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_mem;
  logic             timed_out;
  logic [1:0]       br_eval;
  ctrl_t            ctrl;

  // Returns {legal, taken}; funct3 010/011 are not branch encodings.
  function automatic logic [1:0] branch_eval(input logic [2:0] f3, input logic z,
                                             input logic lt, input logic ltu);
    logic [1:0] r;
    case (f3)
      3'b000:  r = {1'b1, z};
      3'b001:  r = {1'b1, ~z};
      3'b100:  r = {1'b1, lt};
      3'b101:  r = {1'b1, ~lt};
      3'b110:  r = {1'b1, ltu};
      3'b111:  r = {1'b1, ~ltu};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign br_eval   = branch_eval(funct3, zero_flag, lt_flag, ltu_flag);
  assign in_mem    = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timed_out = (MEM_TIMEOUT != 0) && in_mem && !mem_ready && (wait_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      cause <= 2'd0;
    end else begin
      state <= state_next;
      cause <= cause_next;
    end
  end

  // The counter restarts whenever the state changes, so each memory state gets a fresh budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_mem && !mem_ready && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_next = S_EXECR;
          OP_I:               state_next = S_EXECI;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR_ADR;
          OP_LUI:             state_next = S_LUI;
          OP_AUIPC:           state_next = S_AUIPC;
          OP_LOAD, OP_STORE:  state_next = S_MEMADR;
          OP_BRANCH:          state_next = S_BRANCH;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL, S_JALR_PC: state_next = S_ALUWB;
      S_JALR_ADR: state_next = S_JALR_PC;
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB, S_ALUWB: state_next = S_FETCH;
      S_BRANCH: begin
        if (br_eval[1]) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_b  = 2'd2;
        ctrl.result_src = 2'd2;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_update  = mem_ready;
      end
      S_DECODE, S_AUIPC: begin
        ctrl.alu_src_a = 2'd1;
        ctrl.alu_src_b = 2'd1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = 2'd2;
        ctrl.alu_op    = 3'b010;
      end
      S_EXECI: begin
        ctrl.alu_src_a = 2'd2;
        ctrl.alu_src_b = 2'd1;
        ctrl.alu_op    = 3'b011;
      end
      S_JAL, S_JALR_PC: begin
        ctrl.pc_update = 1'b1;
        ctrl.pc_src    = 1'b1;
        ctrl.alu_src_a = 2'd1;
        ctrl.alu_src_b = 2'd2;
      end
      S_JALR_ADR, S_MEMADR: begin
        ctrl.alu_src_a = 2'd2;
        ctrl.alu_src_b = 2'd1;
      end
      S_LUI: begin
        ctrl.alu_src_a = 2'd3;
        ctrl.alu_src_b = 2'd1;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = mem_ready;
      end
      S_MEMWB: begin
        ctrl.result_src = 2'd1;
        ctrl.reg_write  = 1'b1;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 2'd2;
        ctrl.alu_op    = 3'b001;
        ctrl.branch    = 1'b1;
        ctrl.pc_update = br_eval[1] & br_eval[0];
        ctrl.pc_src    = br_eval[1] & br_eval[0];
      end
      default: ctrl = '0;
    endcase
  end

  // Outputs are forced low while reset is held so an access in flight is dropped at once.
  assign mem_req    = reset_n & ctrl.mem_req;
  assign adr_src    = reset_n & ctrl.adr_src;
  assign ir_write   = reset_n & ctrl.ir_write;
  assign reg_write  = reset_n & ctrl.reg_write;
  assign pc_update  = reset_n & ctrl.pc_update;
  assign pc_src     = reset_n & ctrl.pc_src;
  assign mem_write  = reset_n & ctrl.mem_write;
  assign branch     = reset_n & ctrl.branch;
  assign alu_src_a  = reset_n ? ctrl.alu_src_a  : 2'd0;
  assign alu_src_b  = reset_n ? ctrl.alu_src_b  : 2'd0;
  assign alu_op     = reset_n ? ctrl.alu_op     : 3'd0;
  assign result_src = reset_n ? ctrl.result_src : 2'd0;
  assign fsm_state  = reset_n ? state           : 5'd0;
  assign trap       = reset_n & (state == S_TRAP);
  assign trap_cause = reset_n ? cause           : 2'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level model expands each
// instruction into the per-cycle control pattern and memory handshake it should produce.
module tb_multicycle_control_fsm;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero_flag = 1'b0, lt_flag = 1'b0, ltu_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, adr_src, ir_write, reg_write, pc_update, pc_src, mem_write, branch, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, trap_cause;
  logic [2:0] alu_op;
  logic [4:0] fsm_state;

  typedef struct packed {
    logic [4:0] st;
    logic       mreq, adr, irw, regw, pcu, pcs, mw, br;
    logic [1:0] a, b;
    logic [2:0] op;
    logic [1:0] rs;
    logic       trap;
    logic [1:0] cause;
  } obs_t;

  typedef struct packed {
    logic rdy;
    obs_t exp;
  } ent_t;

  obs_t obs;
  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  assign obs = {fsm_state, mem_req, adr_src, ir_write, reg_write, pc_update, pc_src, mem_write,
                branch, alu_src_a, alu_src_b, alu_op, result_src, trap, trap_cause};

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .reg_write(reg_write),
    .pc_update(pc_update), .pc_src(pc_src), .mem_write(mem_write), .branch(branch),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .fsm_state(fsm_state), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got=%h required=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Control pattern for one cycle spent in state st, as listed in the state tables.
  function automatic obs_t st_out(input int st, input bit rdy, input bit taken);
    obs_t o = '0;
    o.st = 5'(st);
    case (st)
      0:  begin o.mreq = 1; o.b = 2'd2; o.rs = 2'd2; o.irw = rdy; o.pcu = rdy; end
      1:  begin o.a = 2'd1; o.b = 2'd1; end
      2:  begin o.a = 2'd2; o.op = 3'b010; end
      3:  begin o.a = 2'd2; o.b = 2'd1; o.op = 3'b011; end
      4, 6: begin o.pcu = 1; o.pcs = 1; o.a = 2'd1; o.b = 2'd2; end
      5, 9: begin o.a = 2'd2; o.b = 2'd1; end
      7:  begin o.a = 2'd3; o.b = 2'd1; end
      8:  begin o.a = 2'd1; o.b = 2'd1; end
      10: begin o.mreq = 1; o.adr = 1; end
      11: begin o.mreq = 1; o.adr = 1; o.mw = rdy; end
      12: begin o.rs = 2'd1; o.regw = 1; end
      13: o.regw = 1;
      14: begin o.a = 2'd2; o.op = 3'b001; o.br = 1; o.pcu = taken; o.pcs = taken; end
      15: o.trap = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input bit rdy, input obs_t e);
    ent_t x;
    x.rdy = rdy;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic pstate(input int st);
    push(1'($urandom), st_out(st, 0, 0));
  endtask

  task automatic push_trap(input logic [1:0] cause);
    obs_t e;
    e = st_out(15, 0, 0);
    e.cause = cause;
    repeat (3) push(1'($urandom), e);
  endtask

  // w not-ready cycles then completion; beyond the timeout budget the access traps instead.
  task automatic mem_phase(input int st, input int w, output bit ok);
    if (w <= TMO) begin
      repeat (w) push(1'b0, st_out(st, 0, 0));
      push(1'b1, st_out(st, 1, 0));
      ok = 1;
    end else begin
      repeat (TMO + 1) push(1'b0, st_out(st, 0, 0));
      push_trap(2'd2);
      ok = 0;
    end
  endtask

  task automatic gen_instr(input logic [6:0] opc, input logic [2:0] f3, input bit z,
                           input bit lt, input bit ltu, input int wf, input int wm,
                           output bit trapped);
    bit ok;
    bit legal_br;
    bit taken;
    trapped = 0;
    mem_phase(0, wf, ok);
    if (!ok) begin trapped = 1; return; end
    pstate(1);
    case (opc)
      7'b0110011: begin pstate(2); pstate(13); end
      7'b0010011: begin pstate(3); pstate(13); end
      7'b1101111: begin pstate(4); pstate(13); end
      7'b1100111: begin pstate(5); pstate(6); pstate(13); end
      7'b0110111: begin pstate(7); pstate(13); end
      7'b0010111: begin pstate(8); pstate(13); end
      7'b0000011: begin
        pstate(9);
        mem_phase(10, wm, ok);
        if (ok) pstate(12); else trapped = 1;
      end
      7'b0100011: begin
        pstate(9);
        mem_phase(11, wm, ok);
        if (!ok) trapped = 1;
      end
      7'b1100011: begin
        legal_br = 1;
        case (f3)
          3'd0: taken = z;
          3'd1: taken = !z;
          3'd4: taken = lt;
          3'd5: taken = !lt;
          3'd6: taken = ltu;
          3'd7: taken = !ltu;
          default: begin taken = 0; legal_br = 0; end
        endcase
        push(1'($urandom), st_out(14, 0, taken));
        if (!legal_br) begin push_trap(2'd1); trapped = 1; end
      end
      default: begin push_trap(2'd1); trapped = 1; end
    endcase
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    mem_ready = 1'b1;
    #1;
    check("reset_async", {7'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_held", {7'd0, obs}, 32'd0);
    reset_n = 1'b1;
  endtask

  // Plays the queue one cycle per entry; abort_st >= 0 pulses reset in that state.
  task automatic run_q(input int abort_st, output bit aborted);
    ent_t e;
    aborted = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      @(negedge clk);
      check($sformatf("cycle_st%0d", e.exp.st), {7'd0, obs}, {7'd0, e.exp});
      if (abort_st >= 0 && int'(e.exp.st) == abort_st) begin
        q.delete();
        do_reset();
        aborted = 1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input bit z, input bit lt,
                       input bit ltu, input int wf, input int wm, input int abort_st);
    bit trapped;
    bit aborted;
    opcode = opc;
    funct3 = f3;
    zero_flag = z;
    lt_flag = lt;
    ltu_flag = ltu;
    gen_instr(opc, f3, z, lt, ltu, wf, wm, trapped);
    run_q(abort_st, aborted);
    if (trapped && !aborted) do_reset();
  endtask

  function automatic bit is_legal(input logic [6:0] opc);
    case (opc)
      7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b0000011, 7'b0100011, 7'b1100011: return 1;
      default: return 0;
    endcase
  endfunction

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111, 7'b0000011, 7'b0100011, 7'b1100011};

  initial begin
    logic [6:0] opc;
    int wf;
    int wm;
    do_reset();
    instr(7'b0110011, 3'd0, 0, 0, 0, 0, 0, -1);   // ADD, no wait states
    instr(7'b0000011, 3'd2, 0, 0, 0, 0, 3, -1);   // LW, three waits in MEMREAD
    instr(7'b1100011, 3'd1, 0, 0, 0, 1, 0, -1);   // BNE taken
    instr(7'b1100011, 3'd1, 1, 0, 0, 0, 0, -1);   // BNE not taken
    instr(7'b0000011, 3'd2, 0, 0, 0, TMO, TMO, -1); // ready exactly at the timeout count
    instr(7'b0110011, 3'd0, 0, 0, 0, TMO + 1, 0, -1); // FETCH timeout
    instr(7'b0000000, 3'd0, 0, 0, 0, 0, 0, -1);   // illegal opcode
    instr(7'b1100011, 3'd2, 0, 0, 0, 0, 0, -1);   // illegal branch funct3
    instr(7'b0100011, 3'd2, 0, 0, 0, 0, TMO + 1, -1); // store timeout
    instr(7'b1100111, 3'd0, 0, 0, 0, 0, 0, -1);   // JALR
    instr(7'b0100011, 3'd2, 0, 0, 0, 0, 3, 11);   // reset during MEMWRITE wait
    instr(7'b0010011, 3'd0, 0, 0, 0, 0, 0, -1);   // restart from FETCH
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do opc = 7'($urandom); while (is_legal(opc));
      end else begin
        opc = legal_ops[$urandom_range(0, 8)];
      end
      wf = ($urandom_range(0, 15) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      wm = ($urandom_range(0, 15) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      instr(opc, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), wf, wm, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
